// File: rtl/net_link_bridge_if.sv
// rtl/net_link_bridge_if.sv - processor send/interrupt and byte-link signal bundle
interface net_link_bridge_if;
   logic        snd;
   logic [31:0] interface_data;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic        interrupt_eth;
   logic [31:0] interrupt_source_data;
   logic        tx_full;
   logic        tx_overflow;
   logic        rx_drop;

   modport master (
      output snd, interface_data, tx_ready, rx_byte, rx_valid,
      input  tx_byte, tx_valid, interrupt_eth, interrupt_source_data,
             tx_full, tx_overflow, rx_drop
   );

   modport slave (
      input  snd, interface_data, tx_ready, rx_byte, rx_valid,
      output tx_byte, tx_valid, interrupt_eth, interrupt_source_data,
             tx_full, tx_overflow, rx_drop
   );
endinterface

// File: rtl/net_link_bridge.sv
// rtl/net_link_bridge.sv - word FIFO + MSB-first byte serializer, byte-to-word RX assembler
module net_link_bridge #(
   parameter int FIFO_DEPTH = 4,
   parameter int RX_TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   net_link_bridge_if.slave   bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int IW = $clog2(RX_TIMEOUT + 1);
   localparam logic [AW:0]   DEPTH_C    = (AW + 1)'(FIFO_DEPTH);
   localparam logic [IW-1:0] TIMEOUT_M1 = IW'(RX_TIMEOUT - 1);

   typedef enum logic {S_IDLE, S_SEND} state_t;

   logic [31:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_tx_overflow;
   state_t        r_state;
   logic [31:0]   r_shreg;
   logic [1:0]    r_idx;
   logic          r_tx_valid;

   logic          w_empty, w_full, w_hs, w_pop, w_push;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == DEPTH_C);
   assign w_hs    = r_tx_valid & bus.tx_ready;
   // A final-byte handshake frees the shift register, so the next word is popped on that same edge.
   assign w_pop   = ~w_empty & ((r_state == S_IDLE) | (w_hs & (r_idx == 2'd0)));
   assign w_push  = bus.snd & (~w_full | w_pop);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= bus.interface_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_tx_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push & ~w_pop)      r_count <= r_count + (AW + 1)'(1);
         else if (~w_push & w_pop) r_count <= r_count - (AW + 1)'(1);
         if (bus.snd & w_full & ~w_pop) r_tx_overflow <= 1'b1;
      end
   end

   // Outgoing byte is always shreg[31:24]; the word shifts left one byte per accepted byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_shreg    <= '0;
         r_idx      <= 2'd0;
         r_tx_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_shreg    <= r_mem[r_rd_ptr];
                  r_idx      <= 2'd3;
                  r_tx_valid <= 1'b1;
                  r_state    <= S_SEND;
               end
            end
            S_SEND: begin
               if (w_hs) begin
                  if (r_idx != 2'd0) begin
                     r_shreg <= {r_shreg[23:0], 8'h00};
                     r_idx   <= r_idx - 2'd1;
                  end else if (w_pop) begin
                     r_shreg <= r_mem[r_rd_ptr];
                     r_idx   <= 2'd3;
                  end else begin
                     r_shreg    <= '0;
                     r_tx_valid <= 1'b0;
                     r_state    <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   logic [1:0]    r_rx_cnt;
   logic [23:0]   r_rx_shreg;
   logic [IW-1:0] r_idle;
   logic [31:0]   r_rx_word;
   logic          r_eth;
   logic          r_drop;

   // An arriving byte always wins over a timeout firing on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_cnt   <= 2'd0;
         r_rx_shreg <= '0;
         r_idle     <= '0;
         r_rx_word  <= '0;
         r_eth      <= 1'b0;
         r_drop     <= 1'b0;
      end else begin
         r_eth  <= 1'b0;
         r_drop <= 1'b0;
         if (bus.rx_valid) begin
            r_idle     <= '0;
            r_rx_shreg <= {r_rx_shreg[15:0], bus.rx_byte};
            if (r_rx_cnt == 2'd3) begin
               r_rx_word <= {r_rx_shreg, bus.rx_byte};
               r_eth     <= 1'b1;
               r_rx_cnt  <= 2'd0;
            end else begin
               r_rx_cnt <= r_rx_cnt + 2'd1;
            end
         end else if (r_rx_cnt != 2'd0) begin
            if (r_idle == TIMEOUT_M1) begin
               r_idle   <= '0;
               r_rx_cnt <= 2'd0;
               r_drop   <= 1'b1;
            end else begin
               r_idle <= r_idle + IW'(1);
            end
         end
      end
   end

   assign bus.tx_byte               = r_shreg[31:24];
   assign bus.tx_valid              = r_tx_valid;
   assign bus.tx_full               = w_full;
   assign bus.tx_overflow           = r_tx_overflow;
   assign bus.interrupt_eth         = r_eth;
   assign bus.interrupt_source_data = r_rx_word;
   assign bus.rx_drop               = r_drop;
endmodule

// File: tb/tb_net_link_bridge.sv
// tb/tb_net_link_bridge.sv - directed vector table plus multi-cycle sequences for net_link_bridge
module tb_net_link_bridge;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   net_link_bridge_if bus();

   net_link_bridge dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        snd;
      logic [31:0] data;
      logic        rdy;
      logic        rv;
      logic [7:0]  rb;
      logic        ev;
      logic [7:0]  eb;
      logic        eeth;
      logic [31:0] eisd;
      logic        efull;
   } vec_t;

   vec_t vecs[15];
   logic [7:0] got[$];
   logic [7:0] expq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.snd = 1'b0;
      bus.interface_data = '0;
      bus.tx_ready = 1'b0;
      bus.rx_byte = '0;
      bus.rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b0;
      step();
      step();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic rx_send(input logic [7:0] b);
      bus.rx_valid = 1'b1;
      bus.rx_byte = b;
      step();
      bus.rx_valid = 1'b0;
   endtask

   function automatic vec_t mk(input logic snd, input logic [31:0] data, input logic rdy,
                               input logic rv, input logic [7:0] rb, input logic ev,
                               input logic [7:0] eb, input logic eeth, input logic [31:0] eisd,
                               input logic efull);
      vec_t v;
      v.snd = snd; v.data = data; v.rdy = rdy; v.rv = rv; v.rb = rb;
      v.ev = ev; v.eb = eb; v.eeth = eeth; v.eisd = eisd; v.efull = efull;
      return v;
   endfunction

   // Streams bytes accepted by the link; optional sends of base+c on the first nsnd cycles.
   task automatic collect(input int cycles, input int nsnd, input logic [31:0] base,
                          output int first, output int last);
      got.delete();
      first = -1;
      last = -1;
      bus.tx_ready = 1'b1;
      for (int c = 0; c < cycles; c++) begin
         bus.snd = (c < nsnd);
         bus.interface_data = base + 32'(c);
         if (bus.tx_valid && bus.tx_ready) begin
            got.push_back(bus.tx_byte);
            if (first < 0) first = c;
            last = c;
         end
         step();
      end
      bus.snd = 1'b0;
   endtask

   task automatic cmp_stream(input string name);
      chk({name, "_len"}, 32'(got.size()), 32'(expq.size()));
      for (int i = 0; i < expq.size() && i < got.size(); i++)
         chk($sformatf("%s_byte%0d", name, i), {24'h0, got[i]}, {24'h0, expq[i]});
   endtask

   task automatic push_word(input logic [31:0] w);
      expq.push_back(w[31:24]);
      expq.push_back(w[23:16]);
      expq.push_back(w[15:8]);
      expq.push_back(w[7:0]);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int first, last, first_drop, drops;

      vecs[0]  = mk(1, 32'hDEADBEEF, 1, 0, 8'h00, 0, 8'h00, 0, 32'h0, 0);
      vecs[1]  = mk(0, 32'h0, 1, 0, 8'h00, 1, 8'hDE, 0, 32'h0, 0);
      vecs[2]  = mk(0, 32'h0, 1, 0, 8'h00, 1, 8'hAD, 0, 32'h0, 0);
      vecs[3]  = mk(0, 32'h0, 1, 0, 8'h00, 1, 8'hBE, 0, 32'h0, 0);
      vecs[4]  = mk(0, 32'h0, 1, 0, 8'h00, 1, 8'hEF, 0, 32'h0, 0);
      vecs[5]  = mk(0, 32'h0, 1, 0, 8'h00, 0, 8'h00, 0, 32'h0, 0);
      vecs[6]  = mk(0, 32'h0, 0, 1, 8'h12, 0, 8'h00, 0, 32'h0, 0);
      vecs[7]  = mk(0, 32'h0, 0, 0, 8'h00, 0, 8'h00, 0, 32'h0, 0);
      vecs[8]  = mk(0, 32'h0, 0, 1, 8'h34, 0, 8'h00, 0, 32'h0, 0);
      vecs[9]  = mk(0, 32'h0, 0, 0, 8'h00, 0, 8'h00, 0, 32'h0, 0);
      vecs[10] = mk(0, 32'h0, 0, 0, 8'h00, 0, 8'h00, 0, 32'h0, 0);
      vecs[11] = mk(0, 32'h0, 0, 0, 8'h00, 0, 8'h00, 0, 32'h0, 0);
      vecs[12] = mk(0, 32'h0, 0, 1, 8'h56, 0, 8'h00, 0, 32'h0, 0);
      vecs[13] = mk(0, 32'h0, 0, 1, 8'h78, 0, 8'h00, 1, 32'h12345678, 0);
      vecs[14] = mk(0, 32'h0, 0, 0, 8'h00, 0, 8'h00, 0, 32'h12345678, 0);

      do_reset();
      chk("rst_tx_byte", {24'h0, bus.tx_byte}, 32'h0);
      chk("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
      chk("rst_eth", {31'h0, bus.interrupt_eth}, 32'h0);
      chk("rst_isd", bus.interrupt_source_data, 32'h0);
      chk("rst_full", {31'h0, bus.tx_full}, 32'h0);
      chk("rst_overflow", {31'h0, bus.tx_overflow}, 32'h0);
      chk("rst_drop", {31'h0, bus.rx_drop}, 32'h0);

      for (int i = 0; i < 15; i++) begin
         bus.snd = vecs[i].snd;
         bus.interface_data = vecs[i].data;
         bus.tx_ready = vecs[i].rdy;
         bus.rx_valid = vecs[i].rv;
         bus.rx_byte = vecs[i].rb;
         step();
         chk($sformatf("vec%0d_tx_valid", i), {31'h0, bus.tx_valid}, {31'h0, vecs[i].ev});
         if (vecs[i].ev)
            chk($sformatf("vec%0d_tx_byte", i), {24'h0, bus.tx_byte}, {24'h0, vecs[i].eb});
         chk($sformatf("vec%0d_eth", i), {31'h0, bus.interrupt_eth}, {31'h0, vecs[i].eeth});
         chk($sformatf("vec%0d_isd", i), bus.interrupt_source_data, vecs[i].eisd);
         chk($sformatf("vec%0d_full", i), {31'h0, bus.tx_full}, {31'h0, vecs[i].efull});
      end
      idle_inputs();

      // backpressure mid-word
      bus.tx_ready = 1'b1;
      bus.snd = 1'b1;
      bus.interface_data = 32'hDEADBEEF;
      step();
      bus.snd = 1'b0;
      step();
      chk("bp_byte3", {24'h0, bus.tx_byte}, 32'hDE);
      step();
      chk("bp_byte2", {24'h0, bus.tx_byte}, 32'hAD);
      bus.tx_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("bp_hold%0d", k), {23'h0, bus.tx_valid, bus.tx_byte}, 32'h1AD);
      end
      bus.tx_ready = 1'b1;
      step();
      chk("bp_byte1", {23'h0, bus.tx_valid, bus.tx_byte}, 32'h1BE);
      step();
      chk("bp_byte0", {23'h0, bus.tx_valid, bus.tx_byte}, 32'h1EF);
      step();
      chk("bp_done", {31'h0, bus.tx_valid}, 32'h0);

      // overflow: one word sits in the serializer, four in the FIFO, the sixth is dropped
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         bus.snd = 1'b1;
         bus.interface_data = 32'(i);
         step();
      end
      chk("ovf_full", {31'h0, bus.tx_full}, 32'h1);
      chk("ovf_not_yet", {31'h0, bus.tx_overflow}, 32'h0);
      bus.interface_data = 32'h6;
      step();
      bus.snd = 1'b0;
      chk("ovf_set", {31'h0, bus.tx_overflow}, 32'h1);
      chk("ovf_full2", {31'h0, bus.tx_full}, 32'h1);
      collect(30, 0, 32'h0, first, last);
      expq.delete();
      for (int i = 1; i <= 5; i++) push_word(32'(i));
      cmp_stream("ovf_drain");
      chk("ovf_no_bubble", 32'(last - first + 1), 32'd20);
      collect(40, 4, 32'h11, first, last);
      expq.delete();
      for (int i = 0; i < 4; i++) push_word(32'h11 + 32'(i));
      cmp_stream("wrap");
      chk("wrap_no_bubble", 32'(last - first + 1), 32'd16);
      chk("ovf_sticky", {31'h0, bus.tx_overflow}, 32'h1);

      // full FIFO with push on the same edge as a final-byte pop
      do_reset();
      for (int i = 0; i < 5; i++) begin
         bus.snd = 1'b1;
         bus.interface_data = 32'hA0 + 32'(i);
         step();
      end
      bus.snd = 1'b0;
      chk("sim_full", {31'h0, bus.tx_full}, 32'h1);
      bus.tx_ready = 1'b1;
      step();
      step();
      step();
      chk("sim_last_byte", {24'h0, bus.tx_byte}, 32'hA0);
      bus.snd = 1'b1;
      bus.interface_data = 32'hA5;
      step();
      bus.snd = 1'b0;
      chk("sim_no_overflow", {31'h0, bus.tx_overflow}, 32'h0);
      chk("sim_still_full", {31'h0, bus.tx_full}, 32'h1);
      collect(30, 0, 32'h0, first, last);
      expq.delete();
      for (int i = 1; i <= 5; i++) push_word(32'hA0 + 32'(i));
      cmp_stream("sim_drain");

      // RX timeout discards partial word only
      do_reset();
      rx_send(8'hCA); rx_send(8'hFE); rx_send(8'hF0); rx_send(8'h0D);
      chk("to_word", bus.interrupt_source_data, 32'hCAFEF00D);
      rx_send(8'hAA);
      rx_send(8'hBB);
      first_drop = -1;
      drops = 0;
      for (int k = 1; k <= 1100; k++) begin
         step();
         if (bus.rx_drop) begin
            if (first_drop < 0) first_drop = k;
            drops++;
         end
      end
      chk("to_drop_cycle", 32'(first_drop), 32'd1024);
      chk("to_drop_count", 32'(drops), 32'd1);
      chk("to_isd_kept", bus.interrupt_source_data, 32'hCAFEF00D);
      rx_send(8'h01); rx_send(8'h02); rx_send(8'h03);
      bus.rx_valid = 1'b1;
      bus.rx_byte = 8'h04;
      step();
      bus.rx_valid = 1'b0;
      chk("to_next_word", bus.interrupt_source_data, 32'h01020304);
      chk("to_next_eth", {31'h0, bus.interrupt_eth}, 32'h1);
      step();
      chk("to_next_eth_clr", {31'h0, bus.interrupt_eth}, 32'h0);

      // byte arriving on the edge the timeout would fire
      rx_send(8'h55);
      drops = 0;
      for (int k = 1; k <= 1023; k++) begin
         step();
         if (bus.rx_drop) drops++;
      end
      rx_send(8'h66);
      if (bus.rx_drop) drops++;
      rx_send(8'h77);
      if (bus.rx_drop) drops++;
      rx_send(8'h88);
      chk("edge_no_drop", 32'(drops), 32'd0);
      chk("edge_word", bus.interrupt_source_data, 32'h55667788);

      // asynchronous reset mid-word, TX and RX
      bus.tx_ready = 1'b1;
      bus.snd = 1'b1;
      bus.interface_data = 32'hDEADBEEF;
      bus.rx_valid = 1'b1;
      bus.rx_byte = 8'h99;
      step();
      bus.snd = 1'b0;
      bus.rx_byte = 8'h98;
      step();
      bus.rx_valid = 1'b0;
      step();
      chk("mid_pre_valid", {31'h0, bus.tx_valid}, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
      chk("mid_tx_byte", {24'h0, bus.tx_byte}, 32'h0);
      chk("mid_isd", bus.interrupt_source_data, 32'h0);
      chk("mid_full", {31'h0, bus.tx_full}, 32'h0);
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      rx_send(8'h0A); rx_send(8'h0B); rx_send(8'h0C); rx_send(8'h0D);
      chk("mid_rx_clean", bus.interrupt_source_data, 32'h0A0B0C0D);
      chk("mid_tx_idle", {31'h0, bus.tx_valid}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
